cic_pdm_stereo: RTL and testbench

CIC_PDM_STEREO -- requirements
Module: cic_pdm_stereo

---
 rtl/cic_pdm_stereo.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_cic_pdm_stereo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cic_pdm_stereo.sv
// cic_pdm_stereo: two-channel PDM-to-PCM CIC decimator with a held output pair.
//
// Each channel maps PDM bits to +1/-1 and runs them through ORDER integrators.
// The integrators advance only on pdm_en_i. Every DECIM enabled samples the
// last integrator is captured into a pipelined comb chain. The comb result is
// arithmetic-shifted by scale_shift_i, saturated to OUT_W bits and loaded into
// the output pair.
//
// Optional feature, enabled by defining CIC_PDM_DC_REMOVE_EN:
//   A per-channel leaky DC-removal stage sits after saturation. It adds one
//   cycle of latency.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pdm_en_i        PDM sample strobe; pdm_l_i/pdm_r_i are sampled only when high
//   pdm_l_i/pdm_r_i left/right PDM bits
//   scale_shift_i   arithmetic right shift applied to the CIC output (0..15)
//   pcm_l_o/pcm_r_o signed PCM pair, held while pcm_valid_o && !pcm_ready_i
//   pcm_valid_o     output pair valid
//   pcm_ready_i     consumer accepts the pair when pcm_valid_o && pcm_ready_i
//   sat_o           one-cycle pulse when a loaded pair was clipped
//   overrun_o       sticky: an unaccepted pair was overwritten
//   ovr_clr_i       clears overrun_o; a coincident new overrun wins
module cic_pdm_stereo #(
    parameter int unsigned ORDER = 3,
    parameter int unsigned DECIM = 64,
    parameter int unsigned OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pdm_en_i,
    input  logic                    pdm_l_i,
    input  logic                    pdm_r_i,
    input  logic [3:0]              scale_shift_i,
    output logic signed [OUT_W-1:0] pcm_l_o,
    output logic signed [OUT_W-1:0] pcm_r_o,
    output logic                    pcm_valid_o,
    input  logic                    pcm_ready_i,
    output logic                    sat_o,
    output logic                    overrun_o,
    input  logic                    ovr_clr_i
);

    localparam int unsigned LOG2_D = $clog2(DECIM);
    localparam int unsigned CIC_W  = ORDER * LOG2_D + 2;
    localparam int unsigned CNT_W  = LOG2_D;
    localparam int unsigned NCH    = 2;
`ifdef CIC_PDM_DC_REMOVE_EN
    localparam int unsigned DC_W   = OUT_W + 8;
    localparam int unsigned DC_K   = 6;
    localparam int unsigned SAT_W  = ((CIC_W > DC_W) ? CIC_W : DC_W) + 1;
`else
    localparam int unsigned SAT_W  = ((CIC_W > OUT_W) ? CIC_W : OUT_W) + 1;
`endif
    localparam logic signed [SAT_W-1:0] SAT_MAX =
        {{(SAT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [SAT_W-1:0] SAT_MIN =
        {{(SAT_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Saturate to OUT_W bits; the MSB of the result flags a clip.
    function automatic logic [OUT_W:0] sat_f(input logic signed [SAT_W-1:0] v);
        logic [OUT_W:0] r;
        if (v > SAT_MAX) begin
            r = {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (v < SAT_MIN) begin
            r = {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            r = {1'b0, v[OUT_W-1:0]};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Integrators, decimation counter and comb pipeline
    // ------------------------------------------------------------------
    logic [NCH-1:0]          pdm_c;
    logic                    tick_c;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CIC_W-1:0]        integ_q [NCH][ORDER];
    logic [CIC_W-1:0]        integ_d [NCH][ORDER];
    logic [CIC_W-1:0]        samp_q  [NCH];
    logic [CIC_W-1:0]        samp_d  [NCH];
    logic [CIC_W-1:0]        comb_q  [NCH][ORDER];
    logic [CIC_W-1:0]        comb_d  [NCH][ORDER];
    logic [CIC_W-1:0]        dly_q   [NCH][ORDER];
    logic [CIC_W-1:0]        dly_d   [NCH][ORDER];
    logic signed [CIC_W-1:0] shf_q   [NCH];
    logic signed [CIC_W-1:0] shf_d   [NCH];
    // tok_q[0] marks samp_q valid, tok_q[k+1] marks comb stage k valid
    logic [ORDER:0]          tok_q, tok_d;
    logic                    shf_v_q, shf_v_d;

    assign pdm_c  = {pdm_r_i, pdm_l_i};
    assign tick_c = pdm_en_i && (cnt_q == CNT_W'(DECIM - 1));

    // Next-state for integrators, counter and comb chain
    always_comb begin
        cnt_d   = cnt_q;
        integ_d = integ_q;
        samp_d  = samp_q;
        comb_d  = comb_q;
        dly_d   = dly_q;
        shf_d   = shf_q;
        tok_d   = {tok_q[ORDER-1:0], tick_c};
        shf_v_d = tok_q[ORDER];

        if (pdm_en_i) begin
            cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
            for (int c = 0; c < int'(NCH); c++) begin
                // bit 1 -> +1, bit 0 -> -1; integrators wrap modulo 2^CIC_W
                integ_d[c][0] = integ_q[c][0] + (pdm_c[c] ? CIC_W'(1) : {CIC_W{1'b1}});
                for (int k = 1; k < int'(ORDER); k++) begin
                    integ_d[c][k] = integ_q[c][k] + integ_q[c][k-1];
                end
            end
        end

        for (int c = 0; c < int'(NCH); c++) begin
            if (tick_c) begin
                samp_d[c] = integ_q[c][ORDER-1];
            end
            if (tok_q[0]) begin
                comb_d[c][0] = samp_q[c] - dly_q[c][0];
                dly_d[c][0]  = samp_q[c];
            end
            for (int k = 1; k < int'(ORDER); k++) begin
                if (tok_q[k]) begin
                    comb_d[c][k] = comb_q[c][k-1] - dly_q[c][k];
                    dly_d[c][k]  = comb_q[c][k-1];
                end
            end
            // scale_shift_i is sampled as the token leaves the last comb
            if (tok_q[ORDER]) begin
                shf_d[c] = $signed(comb_q[c][ORDER-1]) >>> scale_shift_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            integ_q <= '{default: '0};
            samp_q  <= '{default: '0};
            comb_q  <= '{default: '0};
            dly_q   <= '{default: '0};
            shf_q   <= '{default: '0};
            tok_q   <= '0;
            shf_v_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            integ_q <= integ_d;
            samp_q  <= samp_d;
            comb_q  <= comb_d;
            dly_q   <= dly_d;
            shf_q   <= shf_d;
            tok_q   <= tok_d;
            shf_v_q <= shf_v_d;
        end
    end

    // ------------------------------------------------------------------
    // Saturation (and optional DC removal) producing the load request
    // ------------------------------------------------------------------
    logic             ld_v_c;
    logic             ld_clip_c;
    logic [OUT_W-1:0] ld_pcm_c  [NCH];
    logic [OUT_W:0]   sat_a_c   [NCH];

`ifdef CIC_PDM_DC_REMOVE_EN
    logic signed [OUT_W-1:0] dcin_q [NCH];
    logic signed [OUT_W-1:0] dcin_d [NCH];
    logic                    dcin_clip_q, dcin_clip_d;
    logic                    dcin_v_q, dcin_v_d;
    logic signed [DC_W-1:0]  acc_q  [NCH];
    logic signed [DC_W-1:0]  acc_d  [NCH];
    logic signed [DC_W-1:0]  est_c  [NCH];
    logic signed [SAT_W-1:0] dif_c  [NCH];
    logic [OUT_W:0]          sat_b_c [NCH];

    // First saturation registered, then est = acc>>>6 removed and re-saturated
    always_comb begin
        dcin_d      = dcin_q;
        dcin_clip_d = dcin_clip_q;
        dcin_v_d    = shf_v_q;
        acc_d       = acc_q;
        ld_v_c      = dcin_v_q;
        ld_clip_c   = dcin_clip_q;
        if (shf_v_q) begin
            dcin_clip_d = 1'b0;
        end
        for (int c = 0; c < int'(NCH); c++) begin
            sat_a_c[c] = sat_f(SAT_W'(shf_q[c]));
            if (shf_v_q) begin
                dcin_d[c]   = $signed(sat_a_c[c][OUT_W-1:0]);
                dcin_clip_d = dcin_clip_d | sat_a_c[c][OUT_W];
            end
            est_c[c]    = acc_q[c] >>> DC_K;
            dif_c[c]    = SAT_W'(dcin_q[c]) - SAT_W'(est_c[c]);
            sat_b_c[c]  = sat_f(dif_c[c]);
            ld_pcm_c[c] = sat_b_c[c][OUT_W-1:0];
            ld_clip_c   = ld_clip_c | sat_b_c[c][OUT_W];
            if (dcin_v_q) begin
                acc_d[c] = acc_q[c] + DC_W'(dcin_q[c]) - est_c[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcin_q      <= '{default: '0};
            dcin_clip_q <= 1'b0;
            dcin_v_q    <= 1'b0;
            acc_q       <= '{default: '0};
        end else begin
            dcin_q      <= dcin_d;
            dcin_clip_q <= dcin_clip_d;
            dcin_v_q    <= dcin_v_d;
            acc_q       <= acc_d;
        end
    end
`else
    // Output equals the saturated, scaled CIC value
    always_comb begin
        ld_v_c    = shf_v_q;
        ld_clip_c = 1'b0;
        for (int c = 0; c < int'(NCH); c++) begin
            sat_a_c[c]  = sat_f(SAT_W'(shf_q[c]));
            ld_pcm_c[c] = sat_a_c[c][OUT_W-1:0];
            ld_clip_c   = ld_clip_c | sat_a_c[c][OUT_W];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output holding register with overrun tracking
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] pcm_q [NCH];
    logic [OUT_W-1:0] pcm_d [NCH];
    logic             valid_q, valid_d;
    logic             sat_q, sat_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        pcm_d   = pcm_q;
        valid_d = valid_q;
        sat_d   = 1'b0;
        ovr_d   = ovr_q;
        if (ld_v_c) begin
            pcm_d   = ld_pcm_c;
            valid_d = 1'b1;
            sat_d   = ld_clip_c;
        end else if (valid_q && pcm_ready_i) begin
            valid_d = 1'b0;
        end
        if (ovr_clr_i) begin
            ovr_d = 1'b0;
        end
        // A load coinciding with acceptance is not an overrun
        if (ld_v_c && valid_q && !pcm_ready_i) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcm_q   <= '{default: '0};
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            pcm_q   <= pcm_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
        end
    end

    assign pcm_l_o     = $signed(pcm_q[0]);
    assign pcm_r_o     = $signed(pcm_q[1]);
    assign pcm_valid_o = valid_q;
    assign sat_o       = sat_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_cic_pdm_stereo.sv
// tb_cic_pdm_stereo: scoreboard bench for cic_pdm_stereo (ORDER=3, DECIM=64, OUT_W=16).
// Stimulus pushes hand-computed expected pairs; a negedge monitor pops and
// compares every accepted pair. Early transient pairs are pushed as don't-care.
module tb_cic_pdm_stereo;

    typedef struct {
        logic        chk;
        int          l;
        int          r;
        int          s;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               pdm_en = 1'b1;
    logic               pdm_l = 1'b1;
    logic               pdm_r = 1'b1;
    logic [3:0]         scale = 4'd4;
    logic signed [15:0] pcm_l;
    logic signed [15:0] pcm_r;
    logic               pcm_valid;
    logic               pcm_ready = 1'b1;
    logic               sat;
    logic               overrun;
    logic               ovr_clr = 1'b0;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   t      = 0;
    int   mode_l = 1;
    int   mode_r = 1;
    int   en_div = 1;
    int   en_ph  = 0;
    logic alt    = 1'b0;
    exp_t sb[$];

    cic_pdm_stereo #(.ORDER(3), .DECIM(64), .OUT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .pdm_en_i     (pdm_en),
        .pdm_l_i      (pdm_l),
        .pdm_r_i      (pdm_r),
        .scale_shift_i(scale),
        .pcm_l_o      (pcm_l),
        .pcm_r_o      (pcm_r),
        .pcm_valid_o  (pcm_valid),
        .pcm_ready_i  (pcm_ready),
        .sat_o        (sat),
        .overrun_o    (overrun),
        .ovr_clr_i    (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic push(input logic c, input int l, input int r, input int s);
        exp_t e;
        e.chk = c; e.l = l; e.r = r; e.s = s;
        sb.push_back(e);
    endtask

    function automatic logic pick(input int mode, input logic a);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return a;
    endfunction

    // PDM source: pdm_en duty 1/en_div, bit patterns per channel mode
    initial begin
        forever begin
            @(posedge clk); #1;
            if (pdm_en) alt = ~alt;
            en_ph  = (en_ph + 1) % en_div;
            pdm_en = (en_ph == 0);
            pdm_l  = pick(mode_l, alt);
            pdm_r  = pick(mode_r, ~alt);
        end
    end

    // Monitor: every accepted pair is checked against the scoreboard
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && pcm_valid && pcm_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pair: got l=%0d r=%0d, expected no pair (t=%0d)",
                             pcm_l, pcm_r, t);
                end else begin
                    e = sb.pop_front();
                    if (e.chk) begin
                        chk("pair_l", int'(pcm_l), e.l);
                        chk("pair_r", int'(pcm_r), e.r);
                        chk("pair_sat", int'(sat), e.s);
                    end
                end
            end
        end
    end

    task automatic step_to(input int k);
        while (t < k) begin
            @(posedge clk); #1;
            t++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        t = 0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            t++;
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // All-ones both channels, shift 4: 262144>>4 = 16384
        mode_l = 1; mode_r = 1; scale = 4'd4; en_div = 1;
        do_reset();
        chk("rst_pcm_l", int'(pcm_l), 0);
        chk("rst_pcm_r", int'(pcm_r), 0);
        chk("rst_valid", int'(pcm_valid), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_overrun", int'(overrun), 0);
        repeat (3) push(1'b0, 0, 0, 0);
        repeat (3) push(1'b1, 16384, 16384, 0);
        drain("drain_ones", 450);

        // Left ones clip at shift 3, right zeros land exactly on -32768
        mode_l = 1; mode_r = 0; scale = 4'd3;
        do_reset();
        repeat (3) push(1'b0, 0, 0, 0);
        repeat (3) push(1'b1, 32767, -32768, 1);
        drain("drain_clip", 450);

        // Alternating input cancels; first valid 5 cycles after the tick at edge 64
        mode_l = 2; mode_r = 2; scale = 4'd0;
        do_reset();
        repeat (3) push(1'b0, 0, 0, 0);
        repeat (3) push(1'b1, 0, 0, 0);
        step_to(68);  chk("first_valid_early", int'(pcm_valid), 0);
        step_to(69);  chk("first_valid_rise", int'(pcm_valid), 1);
        step_to(70);  chk("valid_drop_after_accept", int'(pcm_valid), 0);
        step_to(132); chk("second_valid_early", int'(pcm_valid), 0);
        step_to(133); chk("second_valid_rise", int'(pcm_valid), 1);
        drain("drain_alt", 450);

        // Reset with a token in the comb pipeline discards it
        mode_l = 1; mode_r = 1; scale = 4'd4;
        do_reset();
        step_to(66);
        rst = 1'b1;
        step_to(67);
        rst = 1'b0;
        t = 0;
        step_to(68);  chk("flushed_token_valid", int'(pcm_valid), 0);
        push(1'b0, 0, 0, 0);
        step_to(69);  chk("valid_after_mid_rst", int'(pcm_valid), 1);
        drain("drain_mid_rst", 20);

        // Overrun: hold with ready low, overwrite, clear, then load+accept together
        mode_l = 1; mode_r = 1; scale = 4'd4; pcm_ready = 1'b1;
        do_reset();
        repeat (3) push(1'b0, 0, 0, 0);
        push(1'b1, 16384, 16384, 0);
        step_to(262);
        pcm_ready = 1'b0;
        step_to(325);
        chk("hold_valid", int'(pcm_valid), 1);
        chk("hold_pcm_l", int'(pcm_l), 16384);
        chk("hold_overrun", int'(overrun), 0);
        scale = 4'd5;
        step_to(389);
        chk("ovw_valid", int'(pcm_valid), 1);
        chk("ovw_pcm_l", int'(pcm_l), 8192);
        chk("ovw_pcm_r", int'(pcm_r), 8192);
        chk("ovw_overrun", int'(overrun), 1);
        step_to(390);
        ovr_clr = 1'b1;
        step_to(391);
        ovr_clr = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);
        chk("held_after_clr", int'(pcm_l), 8192);
        push(1'b1, 8192, 8192, 0);
        push(1'b1, 8192, 8192, 0);
        step_to(452);
        pcm_ready = 1'b1;
        step_to(453);
        chk("load_accept_overrun", int'(overrun), 0);
        chk("load_accept_valid", int'(pcm_valid), 1);
        step_to(454);
        chk("valid_drop_final", int'(pcm_valid), 0);
        drain("drain_ovr", 20);

        // pdm_en duty 1/4 still converges
        mode_l = 1; mode_r = 1; scale = 4'd4; en_div = 4;
        do_reset();
        repeat (3) push(1'b0, 0, 0, 0);
        repeat (2) push(1'b1, 16384, 16384, 0);
        drain("drain_duty", 1400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
